// File: rtl/nand_seq_alu.sv
// Sequential logic unit: every function is evaluated by reusing one WIDTH-bit NAND stage, one pass per clock.
// Optional pass counter enabled by defining NAND_SEQ_PASS_COUNT_EN.
module nand_seq_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             start_in,
  input  logic [2:0]       op_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] y_out,
  output logic             busy_out,
  output logic             done_out,
  output logic             err_out,
  output logic [15:0]      nand_count_out
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [2:0]       op_r, step, last_step;
  logic [WIDTH-1:0] a_r, b_r, t1, t2, t3, t4;
  logic [WIDTH-1:0] nand_x, nand_y, nand_res;
  logic             err_r;

  always_comb begin
    last_step = 3'd0;
    case (op_r)
      3'd2:       last_step = 3'd1;
      3'd3:       last_step = 3'd2;
      3'd4, 3'd5: last_step = 3'd3;
      3'd6:       last_step = 3'd4;
      default:    last_step = 3'd0;
    endcase
  end

  // Operand routing into the shared NAND stage for each pass of each opcode
  always_comb begin
    nand_x = a_r;
    nand_y = b_r;
    case (op_r)
      3'd1: nand_y = a_r;
      3'd2: if (step == 3'd1) begin nand_x = t1; nand_y = t1; end
      3'd3, 3'd4: begin
        case (step)
          3'd0:    begin nand_x = a_r; nand_y = a_r; end
          3'd1:    begin nand_x = b_r; nand_y = b_r; end
          3'd2:    begin nand_x = t1;  nand_y = t2;  end
          default: begin nand_x = t3;  nand_y = t3;  end
        endcase
      end
      3'd5: begin
        case (step)
          3'd0:    begin nand_x = a_r; nand_y = b_r; end
          3'd1:    begin nand_x = a_r; nand_y = t1;  end
          3'd2:    begin nand_x = t1;  nand_y = b_r; end
          default: begin nand_x = t2;  nand_y = t3;  end
        endcase
      end
      3'd6: begin
        case (step)
          3'd0:    begin nand_x = a_r; nand_y = b_r; end
          3'd1:    begin nand_x = a_r; nand_y = a_r; end
          3'd2:    begin nand_x = b_r; nand_y = b_r; end
          3'd3:    begin nand_x = t2;  nand_y = t3;  end
          default: begin nand_x = t1;  nand_y = t4;  end
        endcase
      end
      default: ;
    endcase
  end

  assign nand_res = ~(nand_x & nand_y);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start_in) state_nxt = (op_in == 3'd7) ? DONE : RUN;
      RUN:  if (step == last_step) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The final pass lands directly in y_out, so no separate fifth scratch register is kept
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state <= IDLE;
      op_r  <= '0;
      step  <= '0;
      a_r   <= '0;
      b_r   <= '0;
      t1    <= '0;
      t2    <= '0;
      t3    <= '0;
      t4    <= '0;
      y_out <= '0;
      err_r <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start_in) begin
            a_r   <= a_in;
            b_r   <= b_in;
            op_r  <= op_in;
            step  <= 3'd0;
            err_r <= (op_in == 3'd7);
          end
        end
        RUN: begin
          case (step)
            3'd0:    t1 <= nand_res;
            3'd1:    t2 <= nand_res;
            3'd2:    t3 <= nand_res;
            3'd3:    t4 <= nand_res;
            default: ;
          endcase
          if (step == last_step) y_out <= nand_res;
          step <= step + 3'd1;
        end
        default: ;
      endcase
    end
  end

  assign busy_out = (state != IDLE);
  assign done_out = (state == DONE);
  assign err_out  = (state == DONE) && err_r;

`ifdef NAND_SEQ_PASS_COUNT_EN
  logic [15:0] pass_count;

  // One NAND pass happens on every RUN cycle; the count sticks at all-ones
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pass_count <= '0;
    end else if (state == RUN && pass_count != 16'hFFFF) begin
      pass_count <= pass_count + 16'd1;
    end
  end

  assign nand_count_out = pass_count;
`else
  assign nand_count_out = 16'd0;
`endif

endmodule

// File: doc/nand_seq_alu.md
NAND_SEQ_ALU -- requirements
Module: nand_seq_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 8, which sets the operand and result width in bits.
REQ-002 SHALL have port clk_in, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port rst_n_in, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port start_in, input, 1 bit: operation request, sampled only while idle.
REQ-005 SHALL have port op_in, input, 3 bits: opcode. 0 NAND, 1 NOT, 2 AND, 3 OR, 4 NOR, 5 XOR, 6 XNOR, 7 illegal.
REQ-006 SHALL have ports a_in and b_in, input, WIDTH bits each: the operands.
REQ-007 SHALL have port y_out, output, WIDTH bits: the registered result, held until the next done.
REQ-008 SHALL have port busy_out, output, 1 bit: high whenever the state is not IDLE.
REQ-009 SHALL have port done_out, output, 1 bit: one-cycle completion pulse.
REQ-010 SHALL have port err_out, output, 1 bit: illegal-opcode flag, valid while done_out is high.
REQ-011 SHALL have port nand_count_out, output, 16 bits: NAND pass counter (see Configuration).

Function
REQ-012 SHALL contain exactly one bitwise WIDTH-bit NAND stage; every function is built by time-multiplexing it, one pass per clock.
REQ-013 SHALL implement states IDLE, RUN and DONE, with transitions:
- IDLE to RUN when start_in=1 and op_in<7.
- IDLE to DONE when start_in=1 and op_in=7.
- RUN to DONE on the edge that computes the final pass.
- DONE to IDLE unconditionally.
REQ-014 SHALL latch a_in, b_in and op_in on the accepting edge; later changes to these inputs SHALL NOT affect the operation in flight.
REQ-015 SHALL execute the following pass sequences (t1..t5 are scratch registers; the last pass writes y_out):
- NAND: t1=nand(a,b).
- NOT: t1=nand(a,a); b is ignored.
- AND: t1=nand(a,b); t2=nand(t1,t1).
- OR: t1=nand(a,a); t2=nand(b,b); t3=nand(t1,t2).
- NOR: the OR sequence, then t4=nand(t3,t3).
- XOR: t1=nand(a,b); t2=nand(a,t1); t3=nand(t1,b); t4=nand(t2,t3).
- XNOR: t1=nand(a,b); t2=nand(a,a); t3=nand(b,b); t4=nand(t2,t3); t5=nand(t1,t4).
REQ-016 SHALL, for an op with N passes (1,1,2,3,4,4,5 for opcodes 0..6) accepted at edge 0, perform passes at edges 1..N, update y_out at edge N, and assert done_out for the cycle following edge N.
REQ-017 SHALL, for opcode 7, leave y_out unchanged, consume zero passes, and assert done_out and err_out together for the cycle after the accepting edge.
REQ-018 SHALL hold err_out at 0 whenever done_out is 0 and for every legal opcode.
REQ-019 SHALL ignore start_in while busy_out=1, including the DONE cycle; the minimum issue interval is N+2 clocks.
REQ-020 SHALL drive busy_out from registered state only, so it has no combinational path from start_in.

Reset
REQ-021 SHALL, while rst_n_in=0, immediately force: state IDLE; y_out, t1..t5 and the latched operands 0; busy_out, done_out and err_out 0; nand_count_out 0.
REQ-022 SHALL, on a reset asserted mid-operation, abort the operation with no done_out pulse; the first start after release SHALL behave exactly as after power-up.

Configuration
REQ-023 SHALL use macro NAND_SEQ_PASS_COUNT_EN.
REQ-024 SHALL, when NAND_SEQ_PASS_COUNT_EN is defined, increment nand_count_out by 1 per executed NAND pass, saturating at 16'hFFFF.
REQ-025 SHALL, when NAND_SEQ_PASS_COUNT_EN is undefined, tie nand_count_out to 0 and include no counter logic.

Verification
REQ-026 SHALL cover XOR: op=5, a=8'hA5, b=8'h0F -> y_out=8'hAA, done_out high 4 clocks after the accepting edge, err_out=0.
REQ-027 SHALL cover XNOR and NOT:
- op=6, a=8'hF0, b=8'hCC -> y_out=8'hC3 after 5 passes.
- op=1, a=8'h3C -> y_out=8'hC3 after 1 pass.
REQ-028 SHALL cover OR and NOR back to back: a=8'h50, b=8'h05 -> OR y_out=8'h55, then NOR y_out=8'hAA. A start_in pulse during busy -> ignored, with no extra done_out.
REQ-029 SHALL cover the illegal opcode: op=7 after a prior result of 8'hAA -> done_out=1 and err_out=1 for one cycle, y_out stays 8'hAA.
REQ-030 SHALL cover reset mid-operation: rst_n_in low during pass 2 of XOR -> outputs 0 immediately and no done_out; then AND a=8'hFF, b=8'h81 -> y_out=8'h81.
REQ-031 SHALL, with NAND_SEQ_PASS_COUNT_EN defined, cover a run of NAND, AND, OR, NOR, XOR and XNOR -> nand_count_out=19; with the macro undefined -> nand_count_out=0.
